sprite_blit: RTL and testbench
==============================

# sprite_blit

Sprite copy engine between the 256×16 sprite ROMs and the frame buffer write port. On a start pulse it drives the ROM address (0–255, one 16×16 RGB565 sprite), absorbs the ROM's registered one-cycle read latency, and emits frame-buffer writes at a destination origin. Transparent pixels and off-screen pixels are dropped. The engine honours write back-pressure. It is the read-side initiator for a sprite ROM and is instantiated once per ROM.

## Interface
- FB_W, 320, frame buffer width in pixels
- FB_H, 240, frame buffer height in pixels
- FB_ADDR_W, 17, frame buffer address width (must hold FB_W*FB_H-1)
- TRANSPARENT, 16'hF81F, RGB565 colour key that is never written
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- dest_x  in  9  sprite origin column, latched on accepted start
- dest_y  in  8  sprite origin row, latched on accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse when the copy completes
- rom_address  out  8  sprite ROM read address
- rom_rgb  in  16  ROM data; reflects the rom_address presented on the previous edge
- fb_wr_en  out  1  write request
- fb_wr_addr  out  FB_ADDR_W  py*FB_W + px
- fb_wr_data  out  16  pixel colour
- fb_ready  in  1  frame buffer accepts the write this cycle when fb_wr_en && fb_ready

## Operation
- The engine has four states:
  - IDLE: waits for start. On start, latch dest_x/dest_y, set idx=0, and go to PRIME.
  - PRIME: rom_address=0 for one cycle, with no write. Then go to STREAM.
  - STREAM: rom_rgb is the data for pixel idx, with row=idx[7:4], col=idx[3:0], px=dest_x+col (10 bits), py=dest_y+row (9 bits).
    - Skip the pixel if rom_rgb==TRANSPARENT, px>=FB_W, or py>=FB_H. A skipped pixel always advances.
    - Otherwise assert fb_wr_en with the computed addr/data. The pixel advances only when fb_ready=1.
    - Advancing at idx==255 goes to DONE. Otherwise idx<=idx+1.
  - DONE: done=1 for one cycle, then IDLE.
- rom_address is combinational: idx+1 when advancing in STREAM with idx<255, otherwise idx (0 in IDLE/PRIME). This gives one pixel per cycle with no bubbles.
- Under back-pressure, rom_address holds steady, so rom_rgb stays valid for the stalled pixel. No data skid register is needed.
- fb_wr_addr/fb_wr_data stay stable while fb_wr_en=1 and fb_ready=0.
- A start that arrives outside IDLE is ignored, with no queuing. dest_x/dest_y changes after acceptance have no effect.
- Address arithmetic uses at least 19-bit intermediates. fb_wr_addr is truncated to FB_ADDR_W only after the bounds check.

## Timing
- Reset values: state=IDLE, idx=0, busy=0, done=0, fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, rom_address=0.
- Reset mid-copy aborts immediately. No further writes occur and no done is issued.
- With fb_ready held 1:
  - start is sampled at edge 0.
  - PRIME occupies cycle 1.
  - Pixels occupy cycles 2–257.
  - done=1 in cycle 258.
  - A new start is accepted at the edge that ends cycle 259 (IDLE).
- Each cycle with fb_wr_en=1 and fb_ready=0 adds exactly one cycle of latency.
- fb_wr_en, fb_wr_addr and fb_wr_data are combinational from state, idx, latched origin and rom_rgb. They have no combinational path from fb_ready.
- rom_address depends combinationally on fb_ready, through the advance decision.

## Structure
- Shared package sprite_pkg holds:
  - SPRITE_DIM=16, SPRITE_WORDS=256, SPRITE_ADDR_W=8
  - the RGB565 typedef (logic [15:0])
  - DEFAULT_TRANSPARENT=16'hF81F
  - the state enum typedef {IDLE, PRIME, STREAM, DONE}
- Single module, no sub-modules. The bench pairs it with a 256×16 registered ROM model that has one-cycle latency.

## Test plan
- Opaque sprite with all words 16'h07E0, dest (10,20), fb_ready=1:
  - exactly 256 writes
  - first write at addr 20*320+10=6410, last at 35*320+25=11225
  - done in cycle 258
- Word n = n (ROM index) with word 5 = 16'hF81F:
  - 255 writes; no write to addr 6415
  - data at each address equals the pixel index
- Clipping at dest (312,232): only cols 0–7 and rows 0–7 are written → 64 writes, max addr 239*320+319=76799.
- fb_ready toggling with a random 50% duty:
  - write sequence identical to the unstalled case
  - addr/data held stable during each stall
  - total cycles = 258 + stall count
- start pulsed again during STREAM: ignored, with exactly one done.
- reset asserted at pixel 100: all outputs zero asynchronously, no done. A new start afterwards completes a full copy.

Source files
------------

// File: rtl/sprite_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sprite_pkg : shared sprite geometry, colour type and blit FSM states   |
// | Revision   : 1.0                                                       |
// +-----------------------------------------------------------------------+
package sprite_pkg;

    localparam int SPRITE_DIM    = 16;
    localparam int SPRITE_WORDS  = 256;
    localparam int SPRITE_ADDR_W = 8;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t DEFAULT_TRANSPARENT = 16'hF81F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_blit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sprite_blit : copies one 16x16 RGB565 sprite from ROM to frame buffer  |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
module sprite_blit
    import sprite_pkg::*;
#(
    parameter int      FB_W        = 320,
    parameter int      FB_H        = 240,
    parameter int      FB_ADDR_W   = 17,
    parameter rgb565_t TRANSPARENT = DEFAULT_TRANSPARENT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [8:0]               dest_x,
    input  logic [7:0]               dest_y,
    output logic                     busy,
    output logic                     done,
    output logic [SPRITE_ADDR_W-1:0] rom_address,
    input  rgb565_t                  rom_rgb,
    output logic                     fb_wr_en,
    output logic [FB_ADDR_W-1:0]     fb_wr_addr,
    output rgb565_t                  fb_wr_data,
    input  logic                     fb_ready
);

    localparam logic [9:0]               C_FB_W     = 10'(FB_W);
    localparam logic [8:0]               C_FB_H     = 9'(FB_H);
    localparam logic [SPRITE_ADDR_W-1:0] C_LAST_IDX = SPRITE_ADDR_W'(SPRITE_WORDS - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SPRITE_ADDR_W-1:0] r_idx;
    logic [8:0]               r_dest_x;
    logic [7:0]               r_dest_y;

    logic [9:0]  w_px;
    logic [8:0]  w_py;
    logic [18:0] w_addr_full;
    logic        w_visible;
    logic        w_write;
    logic        w_advance;

    // Pixel position within the frame; widths leave headroom for off-screen origins.
    assign w_px        = {1'b0, r_dest_x} + {6'd0, r_idx[3:0]};
    assign w_py        = {1'b0, r_dest_y} + {5'd0, r_idx[7:4]};
    assign w_addr_full = 19'(w_py) * 19'(FB_W) + 19'(w_px);

    assign w_visible = (rom_rgb != TRANSPARENT) && (w_px < C_FB_W) && (w_py < C_FB_H);
    assign w_write   = (r_state == STREAM) && w_visible;
    assign w_advance = (r_state == STREAM) && (!w_write || fb_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_dest_x <= '0;
            r_dest_y <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && start) begin
                r_dest_x <= dest_x;
                r_dest_y <= dest_y;
                r_idx    <= '0;
            end else if (w_advance) begin
                // Wraps to 0 after the last pixel so rom_address reads 0 in DONE/IDLE.
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = PRIME;
            PRIME:   w_state_nxt = STREAM;
            STREAM:  if (w_advance && r_idx == C_LAST_IDX) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != IDLE);
        done        = (r_state == DONE);
        fb_wr_en    = w_write;
        fb_wr_addr  = '0;
        fb_wr_data  = '0;
        rom_address = r_idx;
        if (w_write) begin
            fb_wr_addr = FB_ADDR_W'(w_addr_full);
            fb_wr_data = rom_rgb;
        end
        // Fetch one pixel ahead so the registered ROM delivers without bubbles.
        if (w_advance && r_idx != C_LAST_IDX) begin
            rom_address = r_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_blit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sprite_blit : randomized self-checking bench with reference model   |
// | Revision       : 1.0                                                   |
// +-----------------------------------------------------------------------+
module tb_sprite_blit;
    import sprite_pkg::*;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_ADDR_W = 17;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [8:0]           dest_x;
    logic [7:0]           dest_y;
    logic                 busy;
    logic                 done;
    logic [7:0]           rom_address;
    logic [15:0]          rom_rgb;
    logic                 fb_wr_en;
    logic [FB_ADDR_W-1:0] fb_wr_addr;
    logic [15:0]          fb_wr_data;
    logic                 fb_ready;

    logic [15:0] rom_mem [256];

    int n_cmp  = 0;
    int n_fail = 0;

    int exp_a[$], exp_d[$], got_a[$], got_d[$], ref_a[$], ref_d[$];
    int done_cyc, n_done, n_stall, stable_err, busy_after;
    bit timed_out;

    sprite_blit #(
        .FB_W       (FB_W),
        .FB_H       (FB_H),
        .FB_ADDR_W  (FB_ADDR_W),
        .TRANSPARENT(16'hF81F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dest_x     (dest_x),
        .dest_y     (dest_y),
        .busy       (busy),
        .done       (done),
        .rom_address(rom_address),
        .rom_rgb    (rom_rgb),
        .fb_wr_en   (fb_wr_en),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .fb_ready   (fb_ready)
    );

    always #5 clk = ~clk;

    // Registered sprite ROM, one-cycle read latency.
    always @(posedge clk) rom_rgb <= rom_mem[rom_address];

    // Reference: every opaque, on-screen pixel in raster order.
    task automatic build_expected(input int dx, input int dy);
        int px, py;
        exp_a.delete();
        exp_d.delete();
        for (int n = 0; n < 256; n++) begin
            px = dx + (n % 16);
            py = dy + (n / 16);
            if (rom_mem[n] != 16'hF81F && px < FB_W && py < FB_H) begin
                exp_a.push_back(py * FB_W + px);
                exp_d.push_back(int'(rom_mem[n]));
            end
        end
    endtask

    // Index of first difference between got and exp, or -1 when identical.
    function automatic int seq_diff();
        int n;
        n = (got_a.size() > exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            if (i >= got_a.size() || i >= exp_a.size()) return i;
            if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) return i;
        end
        return -1;
    endfunction

    task automatic fill_random(input int transp_one_in);
        for (int n = 0; n < 256; n++) begin
            rom_mem[n] = 16'($urandom);
            if (transp_one_in > 0 && $urandom_range(1, transp_one_in) == 1) rom_mem[n] = 16'hF81F;
            else if (rom_mem[n] == 16'hF81F) rom_mem[n] = 16'h0000;
        end
    endtask

    // Drives one copy and records accepted writes, done timing and stall behaviour.
    task automatic run_copy(input int dx, input int dy, input bit rand_ready, input int extra_start_cyc);
        bit held;
        int ha, hd, cyc, post;
        got_a.delete();
        got_d.delete();
        done_cyc = -1; n_done = 0; n_stall = 0; stable_err = 0; busy_after = -1; timed_out = 0;
        held = 0; ha = 0; hd = 0; post = 0;
        @(negedge clk);
        dest_x = 9'(dx); dest_y = 8'(dy); start = 1'b1; fb_ready = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        dest_x = 9'($urandom);
        dest_y = 8'($urandom);
        cyc = 1;
        forever begin
            start    = (cyc == extra_start_cyc);
            fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(busy);
            if (held && (!fb_wr_en || int'(fb_wr_addr) != ha || int'(fb_wr_data) != hd)) stable_err++;
            held = 0;
            if (fb_wr_en) begin
                if (fb_ready) begin
                    got_a.push_back(int'(fb_wr_addr));
                    got_d.push_back(int'(fb_wr_data));
                end else begin
                    n_stall++;
                    held = 1;
                    ha = int'(fb_wr_addr);
                    hd = int'(fb_wr_data);
                end
            end
            if (done_cyc >= 0) post++;
            if (post > 3 || cyc > 3000) begin
                timed_out = (done_cyc < 0);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        fb_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, done, fb_wr_en, fb_wr_addr, fb_wr_data, rom_address} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b en=%b addr=%0d data=%h rom=%0d, want all 0",
                     busy, done, fb_wr_en, fb_wr_addr, fb_wr_data, rom_address);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, fb_wr_en, rom_address} !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got busy=%b done=%b en=%b rom=%0d, want 0", busy, done, fb_wr_en, rom_address);
        end
    endtask

    task automatic test_opaque();
        int d;
        for (int n = 0; n < 256; n++) rom_mem[n] = 16'h07E0;
        build_expected(10, 20);
        run_copy(10, 20, 0, -1);
        n_cmp++;
        if (got_a.size() != 256) begin
            n_fail++; $display("FAIL opaque_count: got %0d writes, want 256", got_a.size());
        end
        n_cmp++;
        if (got_a.size() == 0 || got_a[0] != 6410) begin
            n_fail++; $display("FAIL opaque_first: got %0d, want 6410", got_a.size() ? got_a[0] : -1);
        end
        n_cmp++;
        if (got_a.size() == 0 || got_a[got_a.size()-1] != 11225) begin
            n_fail++; $display("FAIL opaque_last: got %0d, want 11225", got_a.size() ? got_a[got_a.size()-1] : -1);
        end
        n_cmp++;
        if (timed_out || done_cyc != 258) begin
            n_fail++; $display("FAIL opaque_done_cycle: got %0d, want 258", done_cyc);
        end
        n_cmp++;
        if (busy_after != 0) begin
            n_fail++; $display("FAIL opaque_idle_after_done: got busy=%0d, want 0", busy_after);
        end
        d = seq_diff();
        n_cmp++;
        if (d >= 0) begin
            n_fail++; $display("FAIL opaque_sequence: first difference at write %0d", d);
        end
    endtask

    task automatic test_transparent();
        int bad, off;
        bit hit;
        for (int n = 0; n < 256; n++) rom_mem[n] = 16'(n);
        rom_mem[5] = 16'hF81F;
        build_expected(10, 20);
        run_copy(10, 20, 0, -1);
        n_cmp++;
        if (got_a.size() != 255) begin
            n_fail++; $display("FAIL transp_count: got %0d writes, want 255", got_a.size());
        end
        hit = 0; bad = 0;
        foreach (got_a[i]) begin
            if (got_a[i] == 6415) hit = 1;
            off = got_a[i] - 6410;
            if (got_d[i] != (off / 320) * 16 + (off % 320)) bad++;
        end
        n_cmp++;
        if (hit) begin
            n_fail++; $display("FAIL transp_skip: got a write to 6415, want none");
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL transp_data_index: got %0d bad data words, want 0", bad);
        end
        n_cmp++;
        if (seq_diff() >= 0 || n_done != 1) begin
            n_fail++; $display("FAIL transp_sequence: diff at %0d, done count %0d, want -1 and 1", seq_diff(), n_done);
        end
    endtask

    task automatic test_clip();
        int mx;
        fill_random(0);
        build_expected(312, 232);
        run_copy(312, 232, 0, -1);
        mx = -1;
        foreach (got_a[i]) if (got_a[i] > mx) mx = got_a[i];
        n_cmp++;
        if (got_a.size() != 64) begin
            n_fail++; $display("FAIL clip_count: got %0d writes, want 64", got_a.size());
        end
        n_cmp++;
        if (mx != 76799) begin
            n_fail++; $display("FAIL clip_max_addr: got %0d, want 76799", mx);
        end
        n_cmp++;
        if (seq_diff() >= 0) begin
            n_fail++; $display("FAIL clip_sequence: first difference at write %0d", seq_diff());
        end
    endtask

    task automatic test_backpressure();
        int dx, dy;
        for (int it = 0; it < 4; it++) begin
            fill_random(8);
            dx = (it == 3) ? 310 : $urandom_range(0, 319);
            dy = (it == 3) ? 230 : $urandom_range(0, 239);
            build_expected(dx, dy);
            run_copy(dx, dy, 0, -1);
            ref_a = got_a;
            ref_d = got_d;
            run_copy(dx, dy, 1, -1);
            n_cmp++;
            if (got_a != ref_a || got_d != ref_d || seq_diff() >= 0) begin
                n_fail++; $display("FAIL bp_sequence[%0d]: got %0d writes, want %0d", it, got_a.size(), exp_a.size());
            end
            n_cmp++;
            if (stable_err != 0) begin
                n_fail++; $display("FAIL bp_stable[%0d]: got %0d unstable stalls, want 0", it, stable_err);
            end
            n_cmp++;
            if (timed_out || done_cyc != 258 + n_stall) begin
                n_fail++; $display("FAIL bp_latency[%0d]: got done at %0d, want %0d", it, done_cyc, 258 + n_stall);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dx, dy;
        fill_random(6);
        dx = $urandom_range(0, 319);
        dy = $urandom_range(0, 239);
        build_expected(dx, dy);
        run_copy(dx, dy, 0, 50);
        n_cmp++;
        if (n_done != 1 || done_cyc != 258) begin
            n_fail++; $display("FAIL restart_done: got %0d dones at %0d, want 1 at 258", n_done, done_cyc);
        end
        n_cmp++;
        if (seq_diff() >= 0) begin
            n_fail++; $display("FAIL restart_sequence: first difference at write %0d", seq_diff());
        end
    endtask

    task automatic test_reset_abort();
        int writes, bad;
        for (int n = 0; n < 256; n++) rom_mem[n] = 16'h1234;
        @(negedge clk);
        dest_x = 9'd0; dest_y = 8'd0; start = 1'b1; fb_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        writes = 0;
        for (int c = 1; c <= 101; c++) begin
            @(negedge clk);
            if (fb_wr_en && fb_ready) writes++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (writes != 100 || !fb_wr_en) begin
            n_fail++; $display("FAIL abort_progress: got %0d writes en=%b, want 100 en=1", writes, fb_wr_en);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, fb_wr_en, fb_wr_addr, fb_wr_data, rom_address} !== '0) begin
            n_fail++; $display("FAIL abort_async: got busy=%b done=%b en=%b addr=%0d data=%h, want all 0",
                               busy, done, fb_wr_en, fb_wr_addr, fb_wr_data);
        end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || fb_wr_en) bad++;
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || fb_wr_en || busy) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL abort_quiet: got %0d active cycles after abort, want 0", bad);
        end
        fill_random(10);
        build_expected(40, 100);
        run_copy(40, 100, 0, -1);
        n_cmp++;
        if (seq_diff() >= 0 || n_done != 1 || done_cyc != 258) begin
            n_fail++; $display("FAIL abort_recover: diff %0d dones %0d at %0d, want -1, 1, 258", seq_diff(), n_done, done_cyc);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dest_x   = '0;
        dest_y   = '0;
        fb_ready = 1'b1;
        for (int n = 0; n < 256; n++) rom_mem[n] = '0;
        #12;
        test_reset();
        test_opaque();
        test_transparent();
        test_clip();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
